// File: rtl/vscale_htif_pcr_bridge.sv
// ---------------------------------------------------------------------------
// vscale_htif_pcr_bridge
//
// Purpose:
//   Bridges the 16-bit beat-serial HTIF host channel onto the 64-bit
//   request/response PCR (CSR) port of the vscale core.
//
//   Host protocol:
//   - The first beat is a header.
//     - bit 15 is rw.
//     - bits 11:0 are the CSR address.
//     - bits 14:12 are ignored.
//   - A write header is followed by four data beats, least-significant first.
//   - Every transaction returns four response beats, least-significant first.
//
//   Only one transaction is in flight at a time. All outputs are registered.
//   No combinational path exists from any input to any output.
//
// Optional feature (macro VSCALE_HTIF_PCR_BRIDGE_WRITE_EN):
//   - Defined:
//     - Write transactions are forwarded to the CSR file with pcr_req_rw=1.
//     - The response beats carry the data the CSR file returned.
//   - Undefined (default):
//     - Write transactions still consume their four data beats.
//     - No PCR request is issued.
//     - The host receives 64'hFFFF_FFFF_FFFF_FFFF.
//     - pcr_req_rw is always 0.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   hin_*           host -> bridge beats (valid/ready/16-bit bits)
//   hout_*          bridge -> host response beats (valid/ready/16-bit bits)
//   pcr_req_*       request to CSR file (valid/ready/rw/addr/data)
//   pcr_resp_*      response from CSR file (valid/ready/data)
//   busy            high whenever a transaction is in progress
// ---------------------------------------------------------------------------
module vscale_htif_pcr_bridge #(
    parameter int HTIF_PCR_WIDTH = 64,
    parameter int CSR_ADDR_WIDTH = 12
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      hin_valid,
    output logic                      hin_ready,
    input  logic [15:0]               hin_bits,
    output logic                      hout_valid,
    input  logic                      hout_ready,
    output logic [15:0]               hout_bits,
    output logic                      pcr_req_valid,
    input  logic                      pcr_req_ready,
    output logic                      pcr_req_rw,
    output logic [CSR_ADDR_WIDTH-1:0] pcr_req_addr,
    output logic [HTIF_PCR_WIDTH-1:0] pcr_req_data,
    input  logic                      pcr_resp_valid,
    output logic                      pcr_resp_ready,
    input  logic [HTIF_PCR_WIDTH-1:0] pcr_resp_data,
    output logic                      busy
);

`ifdef VSCALE_HTIF_PCR_BRIDGE_WRITE_EN
    localparam logic WRITE_FWD = 1'b1;
`else
    localparam logic WRITE_FWD = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_HDR  = 3'd0,
        ST_DATA = 3'd1,
        ST_REQ  = 3'd2,
        ST_RESP = 3'd3,
        ST_OUT  = 3'd4
    } state_e;

    state_e                    state_q, state_d;
    logic [1:0]                cnt_q, cnt_d;
    logic                      rw_q, rw_d;
    logic [CSR_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [HTIF_PCR_WIDTH-1:0] data_q, data_d;
    logic [HTIF_PCR_WIDTH-1:0] resp_q, resp_d;
    logic [15:0]               hout_bits_q, hout_bits_d;
    logic                      hin_ready_q;
    logic                      hout_valid_q;
    logic                      req_valid_q;
    logic                      resp_ready_q;
    logic                      busy_q;
    logic                      unused_s;

    // Header bits 14:12 carry no meaning for this bridge.
    assign unused_s = ^hin_bits[14:12];

    // Next-state logic: transaction sequencing, request capture, response capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        data_d  = data_q;
        resp_d  = resp_q;
        case (state_q)
            ST_HDR: begin
                if (hin_valid) begin
                    addr_d = hin_bits[CSR_ADDR_WIDTH-1:0];
                    cnt_d  = 2'd0;
                    if (hin_bits[15]) begin
                        // With forwarding disabled, rw stays 0 even for writes.
                        rw_d    = WRITE_FWD;
                        state_d = ST_DATA;
                    end else begin
                        // Reads always present zero write data.
                        rw_d    = 1'b0;
                        data_d  = {HTIF_PCR_WIDTH{1'b0}};
                        state_d = ST_REQ;
                    end
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_DATA: begin
                if (hin_valid) begin
                    data_d[{cnt_q, 4'b0000} +: 16] = hin_bits;
                    if (cnt_q == 2'd3) begin
                        cnt_d = 2'd0;
                        if (WRITE_FWD) begin
                            state_d = ST_REQ;
                        end else begin
                            // Unforwarded writes answer with an all-ones word.
                            resp_d  = {HTIF_PCR_WIDTH{1'b1}};
                            state_d = ST_OUT;
                        end
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_REQ: begin
                if (pcr_req_ready) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_RESP: begin
                if (pcr_resp_valid) begin
                    resp_d  = pcr_resp_data;
                    cnt_d   = 2'd0;
                    state_d = ST_OUT;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_OUT: begin
                if (hout_ready) begin
                    if (cnt_q == 2'd3) begin
                        cnt_d   = 2'd0;
                        state_d = ST_HDR;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d = ST_HDR;
                cnt_d   = 2'd0;
            end
        endcase
        hout_bits_d = resp_d[{cnt_d, 4'b0000} +: 16];
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_HDR;
            cnt_q        <= 2'd0;
            rw_q         <= 1'b0;
            addr_q       <= {CSR_ADDR_WIDTH{1'b0}};
            data_q       <= {HTIF_PCR_WIDTH{1'b0}};
            resp_q       <= {HTIF_PCR_WIDTH{1'b0}};
            hout_bits_q  <= 16'h0000;
            hin_ready_q  <= 1'b1;
            hout_valid_q <= 1'b0;
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            resp_q       <= resp_d;
            hout_bits_q  <= hout_bits_d;
            hin_ready_q  <= (state_d == ST_HDR) || (state_d == ST_DATA);
            hout_valid_q <= (state_d == ST_OUT);
            req_valid_q  <= (state_d == ST_REQ);
            resp_ready_q <= (state_d == ST_RESP);
            busy_q       <= (state_d != ST_HDR);
        end
    end

    assign hin_ready      = hin_ready_q;
    assign hout_valid     = hout_valid_q;
    assign hout_bits      = hout_bits_q;
    assign pcr_req_valid  = req_valid_q;
    assign pcr_req_rw     = rw_q;
    assign pcr_req_addr   = addr_q;
    assign pcr_req_data   = data_q;
    assign pcr_resp_ready = resp_ready_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_vscale_htif_pcr_bridge.sv
module tb_vscale_htif_pcr_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        hin_valid;
    logic        hin_ready;
    logic [15:0] hin_bits;
    logic        hout_valid;
    logic        hout_ready;
    logic [15:0] hout_bits;
    logic        pcr_req_valid;
    logic        pcr_req_ready;
    logic        pcr_req_rw;
    logic [11:0] pcr_req_addr;
    logic [63:0] pcr_req_data;
    logic        pcr_resp_valid;
    logic        pcr_resp_ready;
    logic [63:0] pcr_resp_data;
    logic        busy;

    int total = 0;
    int bad = 0;
    int req_cycles = 0;

    vscale_htif_pcr_bridge #(.HTIF_PCR_WIDTH(64), .CSR_ADDR_WIDTH(12)) dut (
        .clk            (clk),
        .reset          (reset),
        .hin_valid      (hin_valid),
        .hin_ready      (hin_ready),
        .hin_bits       (hin_bits),
        .hout_valid     (hout_valid),
        .hout_ready     (hout_ready),
        .hout_bits      (hout_bits),
        .pcr_req_valid  (pcr_req_valid),
        .pcr_req_ready  (pcr_req_ready),
        .pcr_req_rw     (pcr_req_rw),
        .pcr_req_addr   (pcr_req_addr),
        .pcr_req_data   (pcr_req_data),
        .pcr_resp_valid (pcr_resp_valid),
        .pcr_resp_ready (pcr_resp_ready),
        .pcr_resp_data  (pcr_resp_data),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Counts cycles in which a PCR request is offered.
    always @(posedge clk) begin
        if (pcr_req_valid === 1'b1) req_cycles <= req_cycles + 1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Offer one host beat and let it transfer.
    task automatic send_beat(input logic [15:0] b);
        int n;
        n = 0;
        hin_valid = 1'b1;
        hin_bits  = b;
        while (hin_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("hin_ready", 64'(hin_ready), 64'd1);
        tick();
        hin_valid = 1'b0;
        hin_bits  = 16'(~b);
    endtask

    // CSR-file side: expect one request, stall it, then answer with r.
    task automatic serve_csr(input logic rw, input logic [11:0] a, input logic [63:0] d,
                             input logic [63:0] r, input int stall);
        int n;
        n = 0;
        while (pcr_req_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("req_valid", 64'(pcr_req_valid), 64'd1);
        for (int i = 0; i < stall; i++) begin
            // A response offered while the request is pending must be ignored.
            pcr_resp_valid = 1'b1;
            pcr_resp_data  = ~r;
            check("req_hold_rw", 64'(pcr_req_rw), 64'(rw));
            check("req_hold_addr", 64'(pcr_req_addr), 64'(a));
            check("req_hold_data", pcr_req_data, d);
            tick();
        end
        pcr_resp_valid = 1'b0;
        check("req_valid_held", 64'(pcr_req_valid), 64'd1);
        check("req_rw", 64'(pcr_req_rw), 64'(rw));
        check("req_addr", 64'(pcr_req_addr), 64'(a));
        check("req_data", pcr_req_data, d);
        check("resp_ready_in_req", 64'(pcr_resp_ready), 64'd0);
        pcr_req_ready = 1'b1;
        tick();
        pcr_req_ready = 1'b0;
        check("req_dropped", 64'(pcr_req_valid), 64'd0);
        check("resp_ready", 64'(pcr_resp_ready), 64'd1);
        repeat ($urandom_range(0, 2)) tick();
        pcr_resp_valid = 1'b1;
        pcr_resp_data  = r;
        tick();
        pcr_resp_valid = 1'b0;
        pcr_resp_data  = 64'h0;
    endtask

    // Host side: drain four response beats, optionally stalling on one of them.
    task automatic collect_out(input logic [63:0] e, input int sbeat, input int scyc);
        int n;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (hout_valid !== 1'b1 && n < 50) begin
                tick();
                n++;
            end
            check("hout_valid", 64'(hout_valid), 64'd1);
            if (k == sbeat) begin
                for (int i = 0; i < scyc; i++) begin
                    check("hout_hold", 64'(hout_bits), 64'(e[16*k +: 16]));
                    tick();
                end
            end
            check("hout_bits", 64'(hout_bits), 64'(e[16*k +: 16]));
            hout_ready = 1'b1;
            tick();
            hout_ready = 1'b0;
        end
        check("out_done", 64'({busy, hin_ready, hout_valid}), 64'd2);
    endtask

    // One complete transaction, expectations derived from the header alone.
    task automatic run_txn(input logic [15:0] hdr, input logic [63:0] wdata, input logic [63:0] rdata,
                           input int req_stall, input int sbeat, input int scyc);
        logic is_wr;
        logic fwd;
        logic [63:0] exp_out;
        int rc0;
        is_wr = hdr[15];
`ifdef VSCALE_HTIF_PCR_BRIDGE_WRITE_EN
        fwd = 1'b1;
`else
        fwd = ~is_wr;
`endif
        rc0 = req_cycles;
        check("idle_busy", 64'(busy), 64'd0);
        send_beat(hdr);
        if (is_wr) begin
            for (int k = 0; k < 4; k++) send_beat(wdata[16*k +: 16]);
        end
        if (fwd) begin
            serve_csr(is_wr, hdr[11:0], is_wr ? wdata : 64'h0, rdata, req_stall);
            exp_out = rdata;
        end else begin
            exp_out = 64'hFFFF_FFFF_FFFF_FFFF;
        end
        collect_out(exp_out, sbeat, scyc);
        if (!fwd) check("no_req_for_write", 64'(req_cycles - rc0), 64'd0);
    endtask

    initial begin
        int rc0;
        int n;
        logic [15:0] hdr;
        reset          = 1'b1;
        hin_valid      = 1'b0;
        hin_bits       = 16'h0;
        hout_ready     = 1'b0;
        pcr_req_ready  = 1'b0;
        pcr_resp_valid = 1'b0;
        pcr_resp_data  = 64'h0;
        tick();
        tick();
        check("rst_outputs", 64'({hin_ready, hout_valid, pcr_req_valid, pcr_resp_ready, busy}), 64'h10);
        check("rst_req_fields", 64'({pcr_req_rw, pcr_req_addr}), 64'd0);
        check("rst_req_data", pcr_req_data, 64'd0);
        check("rst_hout_bits", 64'(hout_bits), 64'd0);
        reset = 1'b0;
        tick();
        check("post_rst_hin_ready", 64'(hin_ready), 64'd1);

        // Read with CSR already ready: minimum latency of three cycles.
        pcr_req_ready  = 1'b1;
        pcr_resp_valid = 1'b1;
        pcr_resp_data  = 64'h6;
        hin_valid      = 1'b1;
        hin_bits       = 16'h0300;
        check("lat_hin_ready", 64'(hin_ready), 64'd1);
        tick();
        hin_valid = 1'b0;
        check("lat_c1", 64'({pcr_req_valid, hout_valid, busy, hin_ready}), 64'b1010);
        check("lat_c1_addr", 64'(pcr_req_addr), 64'h300);
        check("lat_c1_rw", 64'(pcr_req_rw), 64'd0);
        check("lat_c1_data", pcr_req_data, 64'd0);
        tick();
        check("lat_c2", 64'({hout_valid, pcr_resp_ready}), 64'b01);
        tick();
        check("lat_c3", 64'(hout_valid), 64'd1);
        pcr_req_ready  = 1'b0;
        pcr_resp_valid = 1'b0;
        collect_out(64'h6, 4, 0);

        // Write with request backpressure and a host stall on beat 1.
        run_txn(16'h8340, 64'h1122_3344_5566_7788, 64'hA5A5_0123_4567_89AB, 5, 1, 3);
        // Read of the same address afterwards.
        run_txn(16'h0340, 64'h0, 64'h6, 0, 4, 0);

        // Reset part-way through the write data beats.
        rc0 = req_cycles;
        send_beat(16'h8340);
        send_beat(16'h1111);
        send_beat(16'h2222);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_write", 64'({hin_ready, busy, pcr_req_valid, hout_valid}), 64'b1000);
        tick();
        tick();
        check("rst_mid_write_noreq", 64'(req_cycles - rc0), 64'd0);
        run_txn(16'h0301, 64'h0, 64'h0000_0000_0000_0301, 1, 4, 0);

        // Reset during the response beats: remaining beats abandoned.
        send_beat(16'h0123);
        serve_csr(1'b0, 12'h123, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 0);
        n = 0;
        while (hout_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("rst_out_b0", 64'(hout_bits), 64'hF00D);
        hout_ready = 1'b1;
        tick();
        hout_ready = 1'b0;
        check("rst_out_b1", 64'(hout_bits), 64'hCAFE);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_out", 64'({hout_valid, busy, hin_ready}), 64'b001);
        hout_ready = 1'b1;
        repeat (3) tick();
        hout_ready = 1'b0;
        check("rst_mid_out_quiet", 64'(hout_valid), 64'd0);

        // Randomized transactions.
        for (int i = 0; i < 25; i++) begin
            hdr = {1'($urandom), 3'($urandom), 12'($urandom)};
            run_txn(hdr, {$urandom, $urandom}, {$urandom, $urandom},
                    $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
